// File: rtl/i2c_gpio_pkg.sv
// -----------------------------------------------------------------------------
// i2c_gpio_pkg
// Shared definitions for the I2C GPIO-expander master:
//   - FSM state encoding
//   - R/W bit values
//   - quarter-phase values
//   - default 7-bit target address
//   - symbol-to-line lookup used by the master FSM
// No ports (package).
// -----------------------------------------------------------------------------
package i2c_gpio_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ACK_A,
    ST_WDATA,
    ST_ACK_W,
    ST_RDATA,
    ST_MACK,
    ST_STOP
  } state_t;

  localparam logic I2C_WR = 1'b0;
  localparam logic I2C_RD = 1'b1;

  localparam logic [1:0] Q_0 = 2'd0;
  localparam logic [1:0] Q_1 = 2'd1;
  localparam logic [1:0] Q_2 = 2'd2;
  localparam logic [1:0] Q_3 = 2'd3;

  localparam logic [6:0] DEF_SLAVE_ADDR = 7'h20;

  // Returns {scl_oe, sda_oe} for the given symbol and quarter.
  // 1 means "pull low"; 0 releases the line.
  function automatic logic [1:0] sym_lines(state_t st, logic [1:0] q, logic bit_val);
    logic       scl_low;
    logic [1:0] r;
    scl_low = (q == Q_0) || (q == Q_3);
    r       = 2'b00;
    case (st)
      ST_START:                              r = {(q == Q_3), (q == Q_2) || (q == Q_3)};
      ST_STOP:                               r = {(q == Q_0), (q == Q_0) || (q == Q_1)};
      ST_ADDR, ST_WDATA:                     r = {scl_low, ~bit_val};
      ST_ACK_A, ST_ACK_W, ST_RDATA, ST_MACK: r = {scl_low, 1'b0};
      default:                               r = 2'b00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/i2c_gpio_master_if.sv
// -----------------------------------------------------------------------------
// i2c_gpio_master_if
// Request/response and pad signals of the I2C GPIO-expander master.
//   wr_req, wr_data, rd_req      : requests from SoC control logic
//   busy, done, nack             : transaction status
//   rd_data, rd_valid            : read result
//   scl_oe, sda_oe               : open-drain pull-low enables to the pads
//   sda_in                       : synchronised SDA pad value
// Modports:
//   master : the I2C controller itself (drives status and pad enables)
//   slave  : the surroundings (SoC requester plus pad ring)
// -----------------------------------------------------------------------------
interface i2c_gpio_master_if;

  logic       wr_req;
  logic [7:0] wr_data;
  logic       rd_req;
  logic       busy;
  logic       done;
  logic       nack;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       scl_oe;
  logic       sda_oe;
  logic       sda_in;

  modport master (
    input  wr_req, wr_data, rd_req, sda_in,
    output busy, done, nack, rd_data, rd_valid, scl_oe, sda_oe
  );

  modport slave (
    output wr_req, wr_data, rd_req, sda_in,
    input  busy, done, nack, rd_data, rd_valid, scl_oe, sda_oe
  );

endinterface

// File: rtl/i2c_quarter_tick.sv
// -----------------------------------------------------------------------------
// i2c_quarter_tick
// Prescaler dividing clk into quarter-SCL-period ticks.
//   clk      : system clock
//   reset    : asynchronous active-high reset
//   restart  : hold counter and phase at zero (used while the master idles)
//   tick     : high during the last clk cycle of each quarter
//   q        : current quarter phase 0..3, advances on each tick
// -----------------------------------------------------------------------------
module i2c_quarter_tick
  import i2c_gpio_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       restart,
  output logic       tick,
  output logic [1:0] q
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLK_DIV - 1)) && !restart;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      q   <= Q_0;
    end else if (restart) begin
      cnt <= '0;
      q   <= Q_0;
    end else if (tick) begin
      cnt <= '0;
      q   <= q + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_gpio_master.sv
// -----------------------------------------------------------------------------
// i2c_gpio_master
// Single-master I2C controller for the I2C-to-GPIO port expander. Performs
// one-byte writes (expander outputs) and one-byte reads (expander inputs).
// Ports:
//   clk        : system clock
//   reset      : asynchronous active-high reset; releases both lines at once
//   bus        : i2c_gpio_master_if.master (requests, status, pad enables)
//   gpio_int_n : expander change flag, active low (only with macro below)
// Parameters:
//   SLAVE_ADDR : 7-bit expander address
//   CLK_DIV    : clk cycles per quarter SCL period (>= 2)
// Build option:
//   I2C_GPIO_INT_POLL_EN : adds gpio_int_n and self-issued reads while idle.
// -----------------------------------------------------------------------------
module i2c_gpio_master
  import i2c_gpio_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = DEF_SLAVE_ADDR,
  parameter int         CLK_DIV    = 16
) (
  input logic               clk,
  input logic               reset,
`ifdef I2C_GPIO_INT_POLL_EN
  input logic               gpio_int_n,
`endif
  i2c_gpio_master_if.master bus
);

  state_t     state;
  logic [1:0] q;
  logic       tick;
  logic       restart;
  logic       sym_end;
  logic       smp;
  logic [2:0] bit_cnt;
  logic       rw;
  logic       nack_flag;
  logic       accept;
  logic       auto_req;
  logic       req_rw;
  logic       cur_bit;

  logic       busy;
  logic       done;
  logic       nack;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       scl_oe;
  logic       sda_oe;

  logic [7:0] wbyte;
  logic [7:0] tx_byte;
  logic [7:0] rx_shift;

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick),
    .q       (q)
  );

  assign restart = (state == ST_IDLE);
  assign sym_end = tick && (q == Q_3);
  assign smp     = tick && (q == Q_1);
  assign accept  = restart && (bus.wr_req || bus.rd_req || auto_req);
  // A simultaneous write and read resolve to the write.
  assign req_rw  = bus.wr_req ? I2C_WR : I2C_RD;
  assign cur_bit = tx_byte[bit_cnt];

`ifdef I2C_GPIO_INT_POLL_EN
  logic int_s1;
  logic int_s2;
  logic auto_armed;

  // auto_armed drops when an auto-read launches and only comes back once the
  // synced flag has been seen high while idle, so a flag held low cannot
  // trigger back-to-back reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_s1     <= 1'b1;
      int_s2     <= 1'b1;
      auto_armed <= 1'b1;
    end else begin
      int_s1 <= gpio_int_n;
      int_s2 <= int_s1;
      if (accept && auto_req)
        auto_armed <= 1'b0;
      else if ((state == ST_IDLE) && int_s2)
        auto_armed <= 1'b1;
    end
  end

  assign auto_req = auto_armed && !int_s2 && !bus.wr_req && !bus.rd_req;
`else
  assign auto_req = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= 3'd0;
      rw        <= I2C_WR;
      nack_flag <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      nack      <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= 8'h00;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
    end else begin
      done     <= 1'b0;
      nack     <= 1'b0;
      rd_valid <= 1'b0;
      // Line drivers track the symbol table one clk behind the phase counter,
      // which keeps every edge registered and the relative timing intact.
      {scl_oe, sda_oe} <= sym_lines(state, q, cur_bit);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            busy      <= 1'b1;
            rw        <= req_rw;
            nack_flag <= 1'b0;
            state     <= ST_START;
          end
        end
        ST_START: begin
          if (sym_end) begin
            bit_cnt <= 3'd7;
            state   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (sym_end) begin
            if (bit_cnt == 3'd0) state <= ST_ACK_A;
            else                 bit_cnt <= bit_cnt - 3'd1;
          end
        end
        ST_ACK_A: begin
          if (smp) nack_flag <= bus.sda_in;
          if (sym_end) begin
            bit_cnt <= 3'd7;
            if (nack_flag)         state <= ST_STOP;
            else if (rw == I2C_WR) state <= ST_WDATA;
            else                   state <= ST_RDATA;
          end
        end
        ST_WDATA: begin
          if (sym_end) begin
            if (bit_cnt == 3'd0) state <= ST_ACK_W;
            else                 bit_cnt <= bit_cnt - 3'd1;
          end
        end
        ST_ACK_W: begin
          if (smp) nack_flag <= bus.sda_in;
          if (sym_end) state <= ST_STOP;
        end
        ST_RDATA: begin
          if (sym_end) begin
            if (bit_cnt == 3'd0) state <= ST_MACK;
            else                 bit_cnt <= bit_cnt - 3'd1;
          end
        end
        ST_MACK: begin
          if (sym_end) state <= ST_STOP;
        end
        ST_STOP: begin
          if (sym_end) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            nack  <= nack_flag;
            if ((rw == I2C_RD) && !nack_flag) begin
              rd_data  <= rx_shift;
              rd_valid <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Shift/hold registers carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      tx_byte <= {SLAVE_ADDR, req_rw};
      if (bus.wr_req) wbyte <= bus.wr_data;
    end else if ((state == ST_ACK_A) && sym_end) begin
      tx_byte <= wbyte;
    end
    if ((state == ST_RDATA) && smp)
      rx_shift <= {rx_shift[6:0], bus.sda_in};
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.nack     = nack;
  assign bus.rd_valid = rd_valid;
  assign bus.rd_data  = rd_data;
  assign bus.scl_oe   = scl_oe;
  assign bus.sda_oe   = sda_oe;

endmodule

// File: tb/tb_i2c_gpio_master.sv
// -----------------------------------------------------------------------------
// tb_i2c_gpio_master
// Directed bench for i2c_gpio_master with CLK_DIV=4 and a behavioural
// port-expander slave on the open-drain lines. With I2C_GPIO_INT_POLL_EN
// defined, the interrupt-driven auto-read is exercised as well.
// -----------------------------------------------------------------------------
module tb_i2c_gpio_master;

  localparam int CLK_DIV = 4;

  logic clk = 1'b0;
  logic reset;
`ifdef I2C_GPIO_INT_POLL_EN
  logic gpio_int_n;
`endif

  always #5 clk = ~clk;

  i2c_gpio_master_if bus ();

  i2c_gpio_master #(.SLAVE_ADDR(7'h20), .CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef I2C_GPIO_INT_POLL_EN
    .gpio_int_n (gpio_int_n),
`endif
    .bus        (bus)
  );

  // Open-drain wiring: lines are high unless someone pulls them low.
  logic scl_line, sda_line, slv_pull;
  assign scl_line   = ~bus.scl_oe;
  assign sda_line   = ~bus.sda_oe & ~slv_pull;
  assign bus.sda_in = sda_line;

  // Expander slave model
  typedef enum int {M_IDLE, M_ADDR, M_ACKA, M_WDATA, M_ACKW, M_RDATA, M_MACK} mstate_t;
  mstate_t    mst;
  logic       scl_d, sda_d, acked, master_ack;
  logic [7:0] shreg, addr_byte, wr_seen, exp_out, exp_in;
  logic [6:0] slv_addr;
  int         bitcnt, ridx;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mst      <= M_IDLE;
      slv_pull <= 1'b0;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
      bitcnt   <= 0;
      ridx     <= 0;
      acked    <= 1'b0;
      shreg    <= 8'h00;
    end else begin
      scl_d <= scl_line;
      sda_d <= sda_line;
      if (scl_line && scl_d && sda_d && !sda_line) begin
        mst      <= M_ADDR;
        bitcnt   <= 0;
        slv_pull <= 1'b0;
      end else if (scl_line && scl_d && !sda_d && sda_line) begin
        mst      <= M_IDLE;
        slv_pull <= 1'b0;
      end else if (scl_line && !scl_d) begin
        if (mst == M_ADDR || mst == M_WDATA) begin
          shreg  <= {shreg[6:0], sda_line};
          bitcnt <= bitcnt + 1;
        end else if (mst == M_MACK) begin
          master_ack <= sda_line;
        end
      end else if (!scl_line && scl_d) begin
        case (mst)
          M_ADDR: if (bitcnt == 8) begin
            addr_byte <= shreg;
            acked     <= (shreg[7:1] == slv_addr);
            slv_pull  <= (shreg[7:1] == slv_addr);
            mst       <= M_ACKA;
          end
          M_ACKA: begin
            if (!acked) begin
              slv_pull <= 1'b0;
              mst      <= M_IDLE;
            end else if (addr_byte[0]) begin
              slv_pull <= ~exp_in[7];
              ridx     <= 6;
              mst      <= M_RDATA;
            end else begin
              slv_pull <= 1'b0;
              bitcnt   <= 0;
              mst      <= M_WDATA;
            end
          end
          M_WDATA: if (bitcnt == 8) begin
            wr_seen  <= shreg;
            exp_out  <= shreg;
            slv_pull <= 1'b1;
            mst      <= M_ACKW;
          end
          M_ACKW: begin
            slv_pull <= 1'b0;
            mst      <= M_IDLE;
          end
          M_RDATA: begin
            if (ridx >= 0) begin
              slv_pull <= ~exp_in[ridx];
              ridx     <= ridx - 1;
            end else begin
              slv_pull <= 1'b0;
              mst      <= M_MACK;
            end
          end
          M_MACK: mst <= M_IDLE;
          default: ;
        endcase
      end
    end
  end

  int n_chk = 0;
  int n_err = 0;
  int n_done = 0;

  always @(negedge clk) if (bus.done === 1'b1) n_done++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Request pulse: the accepting posedge falls between the two negedges,
  // so the task returns half a cycle after acceptance.
  task automatic pulse_req(input logic w, input logic r, input logic [7:0] d);
    @(negedge clk);
    bus.wr_req  = w;
    bus.rd_req  = r;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_req  = 1'b0;
    bus.rd_req  = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", bus.done, 1'b1);
  endtask

  int cyc;
  int d0;

  initial begin
    reset       = 1'b1;
    bus.wr_req  = 1'b0;
    bus.rd_req  = 1'b0;
    bus.wr_data = 8'h00;
    slv_addr    = 7'h20;
    exp_in      = 8'h3C;
`ifdef I2C_GPIO_INT_POLL_EN
    gpio_int_n  = 1'b1;
`endif
    repeat (3) @(negedge clk);
    check("rst_busy",     bus.busy,     1'b0);
    check("rst_done",     bus.done,     1'b0);
    check("rst_nack",     bus.nack,     1'b0);
    check("rst_rd_valid", bus.rd_valid, 1'b0);
    check("rst_rd_data",  bus.rd_data,  8'h00);
    check("rst_scl_oe",   bus.scl_oe,   1'b0);
    check("rst_sda_oe",   bus.sda_oe,   1'b0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_lines", {bus.scl_oe, bus.sda_oe}, 2'b00);

    // One-byte write of 0xA5
    pulse_req(1'b1, 1'b0, 8'hA5);
    check("wr_busy_after_accept", bus.busy, 1'b1);
    wait_done(400, cyc);
    check("wr_latency",  cyc, 320);
    check("wr_nack",     bus.nack, 1'b0);
    check("wr_busy_end", bus.busy, 1'b0);
    check("wr_rd_valid", bus.rd_valid, 1'b0);
    check("wr_addr",     addr_byte, 8'h40);
    check("wr_byte",     wr_seen, 8'hA5);
    check("wr_exp_out",  exp_out, 8'hA5);
    repeat (10) @(negedge clk);

    // One-byte read, slave returns 0x3C
    pulse_req(1'b0, 1'b1, 8'h00);
    wait_done(400, cyc);
    check("rd_latency",    cyc, 320);
    check("rd_nack",       bus.nack, 1'b0);
    check("rd_valid",      bus.rd_valid, 1'b1);
    check("rd_data",       bus.rd_data, 8'h3C);
    check("rd_addr",       addr_byte, 8'h41);
    check("rd_master_ack", master_ack, 1'b1);
    @(negedge clk);
    check("rd_valid_pulse", bus.rd_valid, 1'b0);
    check("rd_data_hold",   bus.rd_data, 8'h3C);
    repeat (10) @(negedge clk);

    // Address NACK: slave answers at 0x21 only
    slv_addr = 7'h21;
    pulse_req(1'b0, 1'b1, 8'h00);
    wait_done(400, cyc);
    check("nack_latency",  cyc, 44 * CLK_DIV);
    check("nack_flag",     bus.nack, 1'b1);
    check("nack_rd_valid", bus.rd_valid, 1'b0);
    check("nack_rd_data",  bus.rd_data, 8'h3C);
    slv_addr = 7'h20;
    repeat (10) @(negedge clk);

    // Simultaneous write+read, then a read request while busy
    d0 = n_done;
    pulse_req(1'b1, 1'b1, 8'h5A);
    repeat (20) @(negedge clk);
    pulse_req(1'b0, 1'b1, 8'h00);
    wait_done(400, cyc);
    check("sim_nack",     bus.nack, 1'b0);
    check("sim_rd_valid", bus.rd_valid, 1'b0);
    check("sim_addr",     addr_byte, 8'h40);
    check("sim_exp_out",  exp_out, 8'h5A);
    repeat (400) @(negedge clk);
    check("sim_done_count", n_done - d0, 1);
    check("sim_busy_idle",  bus.busy, 1'b0);

    // Reset in the middle of WDATA bit 4 (0xA5: bit 4 is 0, so SDA is pulled)
    pulse_req(1'b1, 1'b0, 8'hA5);
    repeat (210) @(negedge clk);
    check("mid_scl_pulled", bus.scl_oe, 1'b1);
    check("mid_sda_pulled", bus.sda_oe, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_scl",  bus.scl_oe, 1'b0);
    check("mid_rst_sda",  bus.sda_oe, 1'b0);
    check("mid_rst_busy", bus.busy,   1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    pulse_req(1'b1, 1'b0, 8'h3E);
    wait_done(400, cyc);
    check("post_rst_latency", cyc, 320);
    check("post_rst_nack",    bus.nack, 1'b0);
    check("post_rst_exp_out", exp_out, 8'h3E);
    repeat (10) @(negedge clk);

`ifdef I2C_GPIO_INT_POLL_EN
    // Interrupt-driven auto-read
    exp_in = 8'hC3;
    gpio_int_n = 1'b0;
    wait_done(500, cyc);
    check("auto_rd_valid", bus.rd_valid, 1'b1);
    check("auto_rd_data",  bus.rd_data, 8'hC3);
    check("auto_nack",     bus.nack, 1'b0);
    @(negedge clk);
    d0 = n_done;
    repeat (700) @(negedge clk);
    check("auto_no_repeat", n_done - d0, 0);
    check("auto_idle_busy", bus.busy, 1'b0);
    gpio_int_n = 1'b1;
    repeat (10) @(negedge clk);
    exp_in = 8'h96;
    gpio_int_n = 1'b0;
    wait_done(500, cyc);
    check("auto2_rd_valid", bus.rd_valid, 1'b1);
    check("auto2_rd_data",  bus.rd_data, 8'h96);
    gpio_int_n = 1'b1;
    repeat (10) @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_gpio_master.md
Name: i2c_gpio_master

Overview:
- Single-master I2C controller that drives the team's I2C-to-GPIO port expander from the system clock domain.
- Issues one-byte writes (set expander outputs) and one-byte reads (fetch expander inputs) on request.
- SCL and SDA are open-drain: the block only pulls lines low or releases them.
- Sits between the SoC register/control logic and the board-level I2C pads.

Parameters:
- SLAVE_ADDR, 7'h20, 7-bit target address sent after START.
- CLK_DIV, 16, clk cycles per quarter SCL period (>=2); SCL period = 4*CLK_DIV.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- wr_req  input  1  one-cycle pulse: write wr_data to expander
- wr_data  input  8  byte to drive on expander outputs; latched on accepted wr_req
- rd_req  input  1  one-cycle pulse: read expander inputs
- busy  output  1  high from request acceptance through end of STOP
- done  output  1  one-cycle pulse at end of every transaction
- nack  output  1  valid with done; 1 = slave did not ACK
- rd_data  output  8  last byte read; holds until next successful read
- rd_valid  output  1  one-cycle pulse with done on a successful read
- scl_oe  output  1  1 = pull SCL low
- sda_oe  output  1  1 = pull SDA low
- sda_in  input  1  pad value of SDA; pre-synchronised by the pad ring

Behaviour:
- Reset, async: all outputs 0, FSM in IDLE, lines released, quarter counter 0. Reset mid-transaction releases both lines at once; no STOP is generated.
- Quarter tick: a counter counts 0..CLK_DIV-1 and advances phase q (0..3) on wrap. Every symbol (START, bit, STOP) takes exactly 4 quarters.
- Bit symbol:
  - SCL low in q0 and q3, high in q1 and q2.
  - SDA changes only at the q3 to q0 boundary.
  - sda_in is sampled on the q1 to q2 tick.
- START: SDA released and SCL high in q0–q1; SDA low in q2; SCL low in q3.
- STOP: SDA low and SCL low in q0; SCL high in q1; SDA released in q2–q3.
- FSM states: IDLE, START, ADDR, ACK_A, WDATA, ACK_W, RDATA, MACK, STOP.
  - IDLE: accept a request only here.
  - Simultaneous wr_req and rd_req: the write wins and the read is dropped.
  - Requests arriving while busy are ignored.
  - On accepted request: busy=1 the next cycle and the quarter counter restarts.
  - ADDR: 8 bits MSB first: SLAVE_ADDR then R/W (0 = write, 1 = read). Bit counter 7 down to 0.
  - ACK_A: SDA released and sampled. 1 = NACK: set nack, go to STOP. 0: go to WDATA (write) or RDATA (read).
  - WDATA: latched byte MSB first, then ACK_W; the sampled value sets nack; then STOP.
  - RDATA: SDA released. Shift sda_in into an MSB-first shift register on each sample tick.
  - MACK: master NACK (SDA released), since only one byte is read; then STOP.
  - STOP end: done=1 for one cycle; busy=0 the same cycle; return to IDLE.
  - On a read with no nack: rd_data updated and rd_valid=1 in that same cycle.
- Latency: both write and read are START + 9 bits + 9 bits + STOP = 20 symbols = 80*CLK_DIV cycles from acceptance to done.
- An address NACK shortens this to 11 symbols = 44*CLK_DIV cycles.
- No clock stretching and no arbitration: SCL is never read back.

Optional Feature:
- Macro I2C_GPIO_INT_POLL_EN adds input port gpio_int_n (1 bit; the expander's change flag, low = inputs differ from the last snapshot).
- With the macro:
  - gpio_int_n is double-synchronised.
  - While IDLE with no pending request and synced gpio_int_n==0, the block self-issues a read.
  - The resulting done/rd_valid are identical to a requested read.
  - A new auto-read is not started until synced gpio_int_n has been seen high once after the previous auto-read completes.
- Without the macro: the port is absent and no auto-reads occur.

Decomposition:
- Shared package i2c_gpio_pkg holds:
  - FSM state encoding
  - R/W bit constants (I2C_WR=0, I2C_RD=1)
  - quarter-phase constants
  - default SLAVE_ADDR 7'h20
- One natural sub-module: i2c_quarter_tick, the CLK_DIV prescaler producing the tick pulse and the q phase. The FSM stays in the top.

Test Plan:
- CLK_DIV=4, wr_req with wr_data=8'hA5, slave model ACKs:
  - SDA bit sequence is 0x40 then 0xA5.
  - done at cycle 320 after acceptance; nack=0; the expander model's outputs equal 8'hA5.
- rd_req with slave returning 8'h3C:
  - address byte is 0x41; master NACKs the data byte.
  - rd_data=8'h3C and rd_valid=1 with done.
- Slave model at address 7'h21:
  - address NACK gives done with nack=1 after 44*CLK_DIV cycles.
  - no data phase; rd_valid=0; rd_data unchanged.
- wr_req and rd_req pulsed in the same cycle, then rd_req again while busy:
  - only the write executes and exactly one done is produced.
- Assert reset during WDATA bit 4:
  - scl_oe=0, sda_oe=0 and busy=0 immediately.
  - a new wr_req after reset release completes normally.
- With I2C_GPIO_INT_POLL_EN, drive gpio_int_n low:
  - one auto-read completes with rd_valid.
  - holding gpio_int_n low yields no second read until it goes high then low again.
